// File: rtl/mem_wait_bridge.sv
// Memory wait-state bridge: stalls reads for RD_LAT cycles; optional posted-write
// FIFO with read forwarding when MEM_WRITE_BUFFER_EN is defined.
module mem_wait_bridge #(
    parameter int unsigned NBITS    = 8,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned WB_DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-3:0] cpuAddress,
    input  logic [NBITS-1:0] cpuWriteData,
    input  logic             cpuMemRead,
    input  logic             cpuMemWrite,
    output logic [NBITS-1:0] cpuReadData,
    output logic             busy,
    output logic [NBITS-3:0] memAddress,
    output logic [NBITS-1:0] memWriteData,
    input  logic [NBITS-1:0] memReadData,
    output logic             memMemWrite,
    output logic             wbEmpty
);

    localparam int unsigned AW     = NBITS - 2;
    localparam logic [3:0]  LAT_M1 = 4'(RD_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RWAIT = 2'd1,
        RDONE = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rd_busy_c;
    logic       hit_c;

    // Read latency FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read FSM next state; forwarded hits never leave IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_busy_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpuMemRead && !hit_c && (RD_LAT != 0)) begin
                    rd_busy_c = 1'b1;
                    if (RD_LAT == 1) begin
                        state_d = RDONE;
                    end else begin
                        state_d = RWAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            RWAIT: begin
                rd_busy_c = 1'b1;
                if (!cpuMemRead) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == LAT_M1) begin
                        state_d = RDONE;
                    end
                end
            end
            RDONE: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

`ifdef MEM_WRITE_BUFFER_EN
    localparam int unsigned PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int unsigned CW = $clog2(WB_DEPTH + 1);

    logic [AW-1:0]    wb_addr_q [WB_DEPTH];
    logic [NBITS-1:0] wb_data_q [WB_DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_c, empty_c;
    logic             push_c, pop_c, wr_busy_c, read_own_c;
    logic [NBITS-1:0] fwd_data_c;
    logic             hit_raw_c;
    logic [PW-1:0]    idx_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (32'(p) == (WB_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full_c  = (count_q == CW'(WB_DEPTH));
    assign empty_c = (count_q == '0);

    // Youngest matching entry wins: later offsets from the head overwrite earlier ones
    always_comb begin
        hit_raw_c  = 1'b0;
        fwd_data_c = '0;
        idx_c      = rd_ptr_q;
        for (int unsigned k = 0; k < WB_DEPTH; k++) begin
            idx_c = rd_ptr_q + PW'(k);
            if ((CW'(k) < count_q) && (wb_addr_q[idx_c] == cpuAddress)) begin
                hit_raw_c  = 1'b1;
                fwd_data_c = wb_data_q[idx_c];
            end
        end
    end

    assign hit_c      = hit_raw_c && cpuMemRead && (state_q == IDLE);
    assign read_own_c = (state_q != IDLE) || (cpuMemRead && !hit_c);
    assign push_c     = cpuMemWrite && !cpuMemRead && (state_q != RWAIT) && !full_c;
    assign wr_busy_c  = cpuMemWrite && !cpuMemRead && (state_q != RWAIT) && full_c;
    assign pop_c      = !empty_c && !read_own_c;

    // FIFO pointers and occupancy; storage itself needs no reset
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_c) begin
            wb_addr_q[wr_ptr_q] <= cpuAddress;
            wb_data_q[wr_ptr_q] <= cpuWriteData;
        end
    end

    assign busy         = !reset && (rd_busy_c || wr_busy_c);
    assign memAddress   = pop_c ? wb_addr_q[rd_ptr_q] : cpuAddress;
    assign memWriteData = pop_c ? wb_data_q[rd_ptr_q] : cpuWriteData;
    assign memMemWrite  = pop_c && !reset;
    assign wbEmpty      = empty_c;
    assign cpuReadData  = hit_c ? fwd_data_c : memReadData;
`else
    assign hit_c        = 1'b0;
    assign busy         = !reset && rd_busy_c;
    assign memAddress   = cpuAddress;
    assign memWriteData = cpuWriteData;
    assign memMemWrite  = cpuMemWrite && !reset;
    assign wbEmpty      = 1'b1;
    assign cpuReadData  = memReadData;
`endif

endmodule

// File: tb/tb_mem_wait_bridge.sv
// Scoreboard bench for mem_wait_bridge: four lanes with RD_LAT 0,1,3,4 and random traffic.
module tb_mem_wait_bridge;

    localparam int unsigned WBD       = 2;
    localparam int          STALL_ANY = -1;

    logic clock = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    task automatic check(input string name, input int ln, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s lane%0d: got %0h, expected %0h at %0t", name, ln, act, exp, $time);
        end
    endtask

    // Power-on contents of each memory word, distinct per lane
    function automatic logic [7:0] seed(input logic [5:0] a, input int ln);
        return 8'((32'(a) * 37) + 11 + ln);
    endfunction

    for (genvar g = 0; g < 4; g++) begin : lane
        localparam int unsigned LAT = (g == 0) ? 0 : (g == 1) ? 1 : (g == 2) ? 3 : 4;

        logic       reset;
        logic [5:0] cpuAddress;
        logic [7:0] cpuWriteData;
        logic       cpuMemRead, cpuMemWrite;
        logic [7:0] cpuReadData;
        logic       busy;
        logic [5:0] memAddress;
        logic [7:0] memWriteData;
        logic [7:0] memReadData;
        logic       memMemWrite;
        logic       wbEmpty;
        bit         done = 1'b0;

        logic [7:0]  arch [64];
        int          exp_rd_data [$];
        int          exp_rd_stall [$];
        logic [13:0] exp_wr [$];

        // External memory stores value^seed so that it may start zeroed
        logic [7:0] ext_mem [64] = '{default: 8'h00};
        logic [5:0] seen_addr = 6'd0;
        int         run = 0;
        int         age;

        mem_wait_bridge #(.NBITS(8), .RD_LAT(LAT), .WB_DEPTH(WBD)) u_dut (
            .clock       (clock),
            .reset       (reset),
            .cpuAddress  (cpuAddress),
            .cpuWriteData(cpuWriteData),
            .cpuMemRead  (cpuMemRead),
            .cpuMemWrite (cpuMemWrite),
            .cpuReadData (cpuReadData),
            .busy        (busy),
            .memAddress  (memAddress),
            .memWriteData(memWriteData),
            .memReadData (memReadData),
            .memMemWrite (memMemWrite),
            .wbEmpty     (wbEmpty)
        );

        always @(posedge clock) begin
            seen_addr <= memAddress;
            run       <= (memAddress == seen_addr) ? ((run < 100) ? run + 1 : run) : 1;
            if (memMemWrite) ext_mem[memAddress] <= memWriteData ^ seed(memAddress, g);
        end

        // Data is only valid once the address has been stable for LAT cycles
        always_comb begin
            age = (memAddress == seen_addr) ? run : 0;
            memReadData = ext_mem[memAddress] ^ seed(memAddress, g);
            if (age < int'(LAT)) memReadData = ~memReadData;
        end

        task automatic wait_accept();
            int n;
            n = 0;
            @(negedge clock);
            while (busy && n < 64) begin
                @(negedge clock);
                n++;
            end
            check("accept_timeout", g, 32'(busy), 32'd0);
            @(posedge clock);
            #1;
        endtask

        task automatic do_read(input logic [5:0] a, input int stall);
            cpuMemRead  = 1'b1;
            cpuMemWrite = 1'b0;
            cpuAddress  = a;
            exp_rd_data.push_back(int'(arch[a]));
            exp_rd_stall.push_back(stall);
            wait_accept();
        endtask

        task automatic do_write(input logic [5:0] a, input logic [7:0] d);
            cpuMemRead   = 1'b0;
            cpuMemWrite  = 1'b1;
            cpuAddress   = a;
            cpuWriteData = d;
            arch[a]      = d;
            exp_wr.push_back({a, d});
            wait_accept();
        endtask

        task automatic do_idle();
            cpuMemRead  = 1'b0;
            cpuMemWrite = 1'b0;
            @(posedge clock);
            #1;
        endtask

        initial begin : drive
            int r;
            int rand_stall;
            logic [5:0] a;
`ifdef MEM_WRITE_BUFFER_EN
            rand_stall = STALL_ANY;
`else
            rand_stall = int'(LAT);
`endif
            for (int i = 0; i < 64; i++) arch[i] = seed(6'(i), g);
            reset        = 1'b1;
            cpuMemRead   = 1'b0;
            cpuMemWrite  = 1'b1;
            cpuAddress   = 6'h11;
            cpuWriteData = 8'h3C;
            #2;
            check("rst_busy_wr", g, 32'(busy), 32'd0);
            check("rst_memwrite", g, 32'(memMemWrite), 32'd0);
            check("rst_wbempty", g, 32'(wbEmpty), 32'd1);
            cpuMemWrite = 1'b0;
            cpuMemRead  = 1'b1;
            #1;
            check("rst_busy_rd", g, 32'(busy), 32'd0);
            repeat (2) @(posedge clock);
            #1;
            cpuMemRead = 1'b0;
            reset      = 1'b0;
            do_idle();

            // Reset lands asynchronously while the FSM sits in RWAIT with cnt=2
            if (LAT >= 3) begin
                cpuAddress = 6'h2A;
                cpuMemRead = 1'b1;
                @(posedge clock);
                @(posedge clock);
                #2;
                reset = 1'b1;
                #1;
                check("async_rst_busy", g, 32'(busy), 32'd0);
                @(posedge clock);
                #1;
                exp_rd_data.push_back(int'(arch[6'h2A]));
                exp_rd_stall.push_back(int'(LAT));
                reset = 1'b0;
                wait_accept();
                do_idle();
            end

            repeat (3) do_read(6'h10, int'(LAT));
            do_read(6'h04, int'(LAT));
            do_read(6'h08, int'(LAT));
            do_idle();
`ifdef MEM_WRITE_BUFFER_EN
            do_write(6'h04, 8'h5A);
            do_read(6'h04, 0);
`else
            do_write(6'h04, 8'h5A);
            do_read(6'h04, int'(LAT));
`endif
            do_idle();

            for (int i = 0; i < 150; i++) begin
                r = int'($urandom_range(0, 9));
                a = 6'($urandom_range(0, 7));
                if (r < 2)      do_idle();
                else if (r < 6) do_read(a, rand_stall);
                else            do_write(a, 8'($urandom));
            end

            repeat (2 * WBD + 4) do_idle();
            check("rd_queue_left", g, 32'(exp_rd_data.size()), 32'd0);
            check("wr_queue_left", g, 32'(exp_wr.size()), 32'd0);
            check("end_wbempty", g, 32'(wbEmpty), 32'd1);
            check("end_busy", g, 32'(busy), 32'd0);
            done = 1'b1;
        end

        initial begin : monitor
            int stall;
            int es;
            int ed;
            logic [13:0] ew;
            stall = 0;
            forever begin
                @(negedge clock);
                if (reset) begin
                    stall = 0;
                end else begin
                    if (cpuMemRead && cpuMemWrite) begin
                        checks++;
                        errors++;
                        $display("FAIL illegal_rw lane%0d: read and write both high at %0t", g, $time);
                    end
`ifdef MEM_WRITE_BUFFER_EN
                    if (cpuMemRead && busy) check("miss_addr", g, 32'(memAddress), 32'(cpuAddress));
`else
                    check("mem_addr", g, 32'(memAddress), 32'(cpuAddress));
                    check("mem_we", g, 32'(memMemWrite), 32'(cpuMemWrite));
                    check("wbempty_const", g, 32'(wbEmpty), 32'd1);
`endif
                    if (cpuMemRead) begin
                        if (busy) begin
                            stall++;
                        end else if (exp_rd_data.size() == 0) begin
                            check("unexpected_rd", g, 32'd1, 32'd0);
                            stall = 0;
                        end else begin
                            ed = exp_rd_data.pop_front();
                            es = exp_rd_stall.pop_front();
                            check("rd_data", g, 32'(cpuReadData), 32'(ed));
                            if (es == STALL_ANY) begin
                                checks++;
                                if (stall != 0 && stall != int'(LAT)) begin
                                    errors++;
                                    $display("FAIL rd_stall lane%0d: got %0d, expected 0 or %0d", g, stall, LAT);
                                end
                            end else begin
                                check("rd_stall", g, 32'(stall), 32'(es));
                            end
                            stall = 0;
                        end
                    end
                    if (memMemWrite) begin
                        if (exp_wr.size() == 0) begin
                            check("unexpected_wr", g, 32'd1, 32'd0);
                        end else begin
                            ew = exp_wr.pop_front();
                            check("wr_addr_data", g, 32'({memAddress, memWriteData}), 32'(ew));
                        end
                    end
                end
            end
        end
    end

    initial begin
        wait (lane[0].done && lane[1].done && lane[2].done && lane[3].done);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: bench did not complete, got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
